mac_enc: RTL and testbench



---
 rtl/mac_pkg.sv | 48 ++++
 rtl/crc.sv | 52 +++++
 rtl/mac_enc.sv | 235 +++++++++++++++++++++++
 tb/tb_mac_enc.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC transmit path: header word field positions,
// Ethernet frame sizes, the CRC-32 polynomial and residue, the encoder state
// encodings and a bit-reversal helper used when turning the CRC register
// into transmitted FCS bytes.
// ---------------------------------------------------------------------------
package mac_pkg;

  // Header word layout (bits above the port mask are reserved).
  localparam int PMASK_LSB    = 112;
  localparam int PMASK_W      = 4;
  localparam int DST_LSB      = 64;
  localparam int SRC_LSB      = 16;
  localparam int TYPE_LSB     = 0;
  localparam int MAC_W        = 48;
  localparam int TYPE_W       = 16;
  localparam int HDR_FIELDS_W = 112;

  // Frame geometry.
  localparam int MIN_PAYLOAD = 46;
  localparam int HDR_BYTES   = 14;
  localparam int FCS_BYTES   = 4;

  // CRC-32 (IEEE 802.3) in MSB-first register form.
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PAD     = 3'd3,
    S_FCS     = 3'd4,
    S_DRAIN   = 3'd5,
    S_END     = 3'd6
  } encState_t;

  // Reverses the bit order of a 32-bit word.
  function automatic logic [31:0] bitRev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc.sv
// ---------------------------------------------------------------------------
// crc
// Byte-wide CRC-32 engine (polynomial 0x04C11DB7, preset all-ones).
// Bits of each byte are consumed LSB first, matching Ethernet wire order, and
// the register is kept in MSB-first form with no output inversion.  A frame
// followed by its correct FCS leaves CRC_RESIDUE in the register.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous preset to all-ones (active high)
//   crc_en  in   fold data_in into the register this cycle
//   data_in in   byte to accumulate
//   crc_out out  current register value
// ---------------------------------------------------------------------------
module crc
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // One serial CRC step per data bit, unrolled across the byte.
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (crc_d[31] ^ data_in[i]) begin
        crc_d = {crc_d[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_d = {crc_d[30:0], 1'b0};
      end
    end
  end

  // The reset input is built from logic (frame start and system reset), so it
  // is sampled synchronously rather than used as an asynchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '1;
    end else if (crc_en) begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/mac_enc.sv
// ---------------------------------------------------------------------------
// mac_enc
// MAC transmit encoder.  Pops one header word, rebuilds the Ethernet frame
// (DST, SRC, TYPE, body, optional zero pad, optional FCS) and writes it
// byte-serially to every PHY TX FIFO selected by the header port mask.
// A header with an empty port mask drains its body without writing.
//
// Ports:
//   clk, arst_n       clock, asynchronous active-low reset
//   h_fifo_dout/empty header FIFO (first-word fall-through)
//   h_fifo_rden       header pop (combinational)
//   b_fifo_dout/empty body FIFO (first-word fall-through)
//   b_fifo_del        current body byte ends the frame
//   b_fifo_rden       body pop (combinational)
//   o_fifo_din        byte on the shared TX FIFO bus (registered)
//   o_fifo_wren       per-port write enable (registered)
//   o_fifo_del        written byte ends the frame (registered)
//   o_fifo_afull      per-port TX FIFO almost-full
//   frame_done        pulse after a transmitted frame completes
//   frame_drop        pulse after a mask-0 frame has been drained
// ---------------------------------------------------------------------------
module mac_enc
  import mac_pkg::*;
#(
  parameter bit APPEND_FCS    = 1'b1,
  parameter bit PAD_EN        = 1'b1,
  parameter int HEADER_DWIDTH = 128
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
  input  logic                     h_fifo_empty,
  output logic                     h_fifo_rden,
  input  logic [7:0]               b_fifo_dout,
  input  logic                     b_fifo_empty,
  input  logic                     b_fifo_del,
  output logic                     b_fifo_rden,
  output logic [7:0]               o_fifo_din,
  output logic [3:0]               o_fifo_wren,
  output logic                     o_fifo_del,
  input  logic [3:0]               o_fifo_afull,
  output logic                     frame_done,
  output logic                     frame_drop
);

  encState_t                 state_q, state_d;
  logic [HDR_FIELDS_W-1:0]   hdr_q, hdr_d;
  logic [PMASK_W-1:0]        mask_q, mask_d;
  logic [10:0]               cnt_q, cnt_d;
  logic [3:0]                idx_q, idx_d;

  logic [7:0]                din_q;
  logic [3:0]                wren_q;
  logic                      del_q, done_q, drop_q;

  logic                      stall;
  logic                      emit, emitDel, doneD, dropD;
  logic                      crcEn, crcRst, crcRstAll;
  logic [7:0]                emitByte;
  logic [10:0]               cntInc;
  logic [31:0]               crcOut;
  logic [13:0][7:0]          hdrBytes;
  logic [3:0][7:0]           fcsBytes;
  logic                      unusedHdrBits;

  // Reserved header bits carry nothing for the encoder.
  assign unusedHdrBits = ^h_fifo_dout[HEADER_DWIDTH-1:PMASK_LSB+PMASK_W];

  assign stall  = |(o_fifo_afull & mask_q);
  assign cntInc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

  // Byte 13 of this view is DST[47:40], the first byte on the wire.
  assign hdrBytes = hdr_q;

  // Ethernet sends the inverted, bit-reflected CRC, least significant byte
  // first; the CRC register is frozen while these bytes go out.
  assign fcsBytes = ~bitRev32(crcOut);

  // Next-state, pop and emit decisions.  Stall freezes everything except the
  // drain of a dropped frame, which never writes and so cannot overflow.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    h_fifo_rden = 1'b0;
    b_fifo_rden = 1'b0;
    emit        = 1'b0;
    emitByte    = 8'h00;
    emitDel     = 1'b0;
    crcEn       = 1'b0;
    crcRst      = 1'b0;
    doneD       = 1'b0;
    dropD       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!h_fifo_empty) begin
          h_fifo_rden = 1'b1;
          hdr_d       = h_fifo_dout[HDR_FIELDS_W-1:0];
          mask_d      = h_fifo_dout[PMASK_LSB +: PMASK_W];
          crcRst      = 1'b1;
          cnt_d       = '0;
          idx_d       = '0;
          state_d     = (h_fifo_dout[PMASK_LSB +: PMASK_W] == '0) ? S_DRAIN : S_HEADER;
        end
      end

      S_HEADER: begin
        if (!stall) begin
          emit     = 1'b1;
          emitByte = hdrBytes[4'd13 - idx_q];
          crcEn    = 1'b1;
          if (idx_q == 4'(HDR_BYTES - 1)) begin
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      S_PAYLOAD: begin
        if (!stall && !b_fifo_empty) begin
          b_fifo_rden = 1'b1;
          emit        = 1'b1;
          emitByte    = b_fifo_dout;
          crcEn       = 1'b1;
          cnt_d       = cntInc;
          if (b_fifo_del) begin
            if (!APPEND_FCS) begin
              emitDel = 1'b1;
              state_d = S_END;
            end else if (PAD_EN && (cntInc < 11'(MIN_PAYLOAD))) begin
              state_d = S_PAD;
            end else begin
              state_d = S_FCS;
            end
          end
        end
      end

      S_PAD: begin
        if (!stall) begin
          emit  = 1'b1;
          crcEn = 1'b1;
          cnt_d = cntInc;
          if (cntInc >= 11'(MIN_PAYLOAD)) begin
            state_d = S_FCS;
          end
        end
      end

      S_FCS: begin
        if (!stall) begin
          emit     = 1'b1;
          emitByte = fcsBytes[idx_q[1:0]];
          if (idx_q == 4'(FCS_BYTES - 1)) begin
            emitDel = 1'b1;
            idx_d   = '0;
            state_d = S_END;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      S_DRAIN: begin
        if (!b_fifo_empty) begin
          b_fifo_rden = 1'b1;
          if (b_fifo_del) begin
            dropD   = 1'b1;
            state_d = S_END;
          end
        end
      end

      S_END: begin
        doneD   = (mask_q != '0);
        hdr_d   = '0;
        mask_d  = '0;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_END;
    endcase
  end

  // State and frame registers plus the registered output stage.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      din_q   <= '0;
      wren_q  <= '0;
      del_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      din_q   <= emitByte;
      wren_q  <= emit ? mask_q : 4'b0000;
      del_q   <= emit & emitDel;
      done_q  <= doneD;
      drop_q  <= dropD;
    end
  end

  assign crcRstAll = ~arst_n | crcRst;

  crc u_crc (
    .clk     (clk),
    .rst     (crcRstAll),
    .crc_en  (crcEn),
    .data_in (emitByte),
    .crc_out (crcOut)
  );

  assign o_fifo_din  = din_q;
  assign o_fifo_wren = wren_q;
  assign o_fifo_del  = del_q;
  assign frame_done  = done_q;
  assign frame_drop  = drop_q;

endmodule

// File: tb/tb_mac_enc.sv
// ---------------------------------------------------------------------------
// tb_mac_enc
// Directed frame vectors for mac_enc.  A small FWFT model feeds the header and
// body FIFOs, a monitor captures every per-port write, and each frame is
// checked against the bench's own header bytes, payload, padding and an
// independent reflected CRC-32 model.
// ---------------------------------------------------------------------------
module tb_mac_enc;

  logic         clk;
  logic         arst_n;
  logic [127:0] h_fifo_dout;
  logic         h_fifo_empty;
  logic         h_fifo_rden;
  logic [7:0]   b_fifo_dout;
  logic         b_fifo_empty;
  logic         b_fifo_del;
  logic         b_fifo_rden;
  logic [7:0]   o_fifo_din;
  logic [3:0]   o_fifo_wren;
  logic         o_fifo_del;
  logic [3:0]   o_fifo_afull;
  logic         frame_done;
  logic         frame_drop;

  mac_enc #(.APPEND_FCS(1'b1), .PAD_EN(1'b1), .HEADER_DWIDTH(128)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .h_fifo_dout  (h_fifo_dout),
    .h_fifo_empty (h_fifo_empty),
    .h_fifo_rden  (h_fifo_rden),
    .b_fifo_dout  (b_fifo_dout),
    .b_fifo_empty (b_fifo_empty),
    .b_fifo_del   (b_fifo_del),
    .b_fifo_rden  (b_fifo_rden),
    .o_fifo_din   (o_fifo_din),
    .o_fifo_wren  (o_fifo_wren),
    .o_fifo_del   (o_fifo_del),
    .o_fifo_afull (o_fifo_afull),
    .frame_done   (frame_done),
    .frame_drop   (frame_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    int         len;
    int         bubblePct;
    int         stallPops;
    int         stallCycles;
    logic [3:0] stallBits;
    int         expLen;
    bit         expDrop;
  } vec_t;

  vec_t vecs [9];

  // FIFO models and frame bookkeeping.
  logic [127:0] hq [$];
  logic [8:0]   bq [$];
  logic [7:0]   sent [2048];
  logic [7:0]   portBuf [4][2048];
  int           portCnt [4];
  int           delSeen [4];
  int           delIdx [4];
  int           doneCnt, dropCnt, popCnt;
  int           stallAt, stallLeft, stallSeen, stallBad;
  logic [3:0]   stallBits;
  bit           stallNow, prevStall;
  int           bubblePct;
  bit           hPop, bPop;
  logic [47:0]  curDst, curSrc;
  logic [15:0]  curType;

  int vecCount;
  int checkCount;
  int miscompares;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic [31:0] refCrcByte(input logic [31:0] r, input logic [7:0] d);
    logic [31:0] x;
    x = r ^ {24'h0, d};
    for (int b = 0; b < 8; b++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    end
    return x;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [7:0] hdrByte(input logic [47:0] d, input logic [47:0] s,
                                         input logic [15:0] t, input int k);
    logic [47:0] x;
    logic [15:0] y;
    if (k < 6) begin
      x = d >> (8 * (5 - k));
      return x[7:0];
    end else if (k < 12) begin
      x = s >> (8 * (11 - k));
      return x[7:0];
    end
    y = t >> (8 * (13 - k));
    return y[7:0];
  endfunction

  // FIFO driver and output monitor: sample at the falling edge, apply pops
  // and drive new FIFO heads just after the rising edge.
  initial begin
    h_fifo_dout  = '0;
    h_fifo_empty = 1'b1;
    b_fifo_dout  = '0;
    b_fifo_empty = 1'b1;
    b_fifo_del   = 1'b0;
    o_fifo_afull = '0;
    stallNow     = 1'b0;
    prevStall    = 1'b0;
    forever begin
      @(negedge clk);
      if (arst_n) begin
        for (int p = 0; p < 4; p++) begin
          if (o_fifo_wren[p]) begin
            if (portCnt[p] < 2048) portBuf[p][portCnt[p]] = o_fifo_din;
            if (o_fifo_del) begin
              delSeen[p]++;
              delIdx[p] = portCnt[p];
            end
            portCnt[p]++;
          end
        end
        if (frame_done) doneCnt++;
        if (frame_drop) dropCnt++;
        if (b_fifo_rden) popCnt++;
        if (stallNow && b_fifo_rden) stallBad++;
        if (prevStall && (o_fifo_wren != 4'b0000)) stallBad++;
        if (stallNow) stallSeen++;
        prevStall = stallNow;
      end
      hPop = h_fifo_rden;
      bPop = b_fifo_rden;
      @(posedge clk);
      #1;
      if (hPop && hq.size() > 0) void'(hq.pop_front());
      if (bPop && bq.size() > 0) void'(bq.pop_front());
      h_fifo_empty = (hq.size() == 0);
      h_fifo_dout  = (hq.size() > 0) ? hq[0] : '0;
      b_fifo_empty = (bq.size() == 0) ||
                     ((bubblePct > 0) && ($urandom_range(99) < bubblePct));
      b_fifo_dout  = (bq.size() > 0) ? bq[0][7:0] : 8'h00;
      b_fifo_del   = (bq.size() > 0) ? bq[0][8] : 1'b0;
      if (stallLeft > 0 && popCnt >= stallAt) begin
        o_fifo_afull = stallBits;
        stallLeft--;
        stallNow = 1'b1;
      end else begin
        o_fifo_afull = '0;
        stallNow     = 1'b0;
      end
    end
  end

  // Loads one frame (header plus body) into the FIFO models.
  task automatic applyStimulus(input int v);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      portCnt[p] = 0;
      delSeen[p] = 0;
      delIdx[p]  = -1;
    end
    doneCnt   = 0;
    dropCnt   = 0;
    popCnt    = 0;
    stallSeen = 0;
    stallBad  = 0;
    stallAt   = vecs[v].stallPops;
    stallLeft = vecs[v].stallCycles;
    stallBits = vecs[v].stallBits;
    bubblePct = vecs[v].bubblePct;
    curDst    = 48'h0A1B_2C3D_4E50 + 48'(v);
    curSrc    = 48'h0211_2233_4450 + 48'(v);
    curType   = 16'h0800 + 16'(v);
    for (int i = 0; i < vecs[v].len; i++) begin
      sent[i] = 8'($urandom_range(255));
      bq.push_back({(i == vecs[v].len - 1), sent[i]});
    end
    hq.push_back({12'hABC, vecs[v].mask, curDst, curSrc, curType});
  endtask

  // Waits for the frame to finish and checks everything captured for it.
  task automatic checkFrame(input int v);
    int waitC;
    int refP;
    int n;
    int bad;
    logic [31:0] r;
    waitC = 0;
    while ((doneCnt + dropCnt) == 0 && waitC < 20000) begin
      @(negedge clk);
      waitC++;
    end
    repeat (4) @(negedge clk);
    checkOutput($sformatf("v%0d frameEnd", v), doneCnt + dropCnt, 1);
    checkOutput($sformatf("v%0d frameDone", v), doneCnt, vecs[v].expDrop ? 0 : 1);
    checkOutput($sformatf("v%0d frameDrop", v), dropCnt, vecs[v].expDrop ? 1 : 0);
    checkOutput($sformatf("v%0d bodyPops", v), popCnt, vecs[v].len);
    for (int p = 0; p < 4; p++) begin
      checkOutput($sformatf("v%0d port%0d writes", v, p), portCnt[p],
                  vecs[v].mask[p] ? vecs[v].expLen : 0);
    end
    checkOutput($sformatf("v%0d stallBad", v), stallBad, 0);
    checkOutput($sformatf("v%0d stallCycles", v), stallSeen, vecs[v].stallCycles);

    if (vecs[v].mask != 4'b0000) begin
      refP = 0;
      while (!vecs[v].mask[refP]) refP++;
      n = (portCnt[refP] < 2048) ? portCnt[refP] : 2048;

      bad = 0;
      for (int k = 0; k < 14; k++) begin
        if (portBuf[refP][k] !== hdrByte(curDst, curSrc, curType, k)) bad++;
      end
      checkOutput($sformatf("v%0d hdrBytes", v), bad, 0);

      bad = 0;
      for (int i = 0; i < vecs[v].len; i++) begin
        if (portBuf[refP][14+i] !== sent[i]) bad++;
      end
      checkOutput($sformatf("v%0d payload", v), bad, 0);

      bad = 0;
      for (int i = 14 + vecs[v].len; i < vecs[v].expLen - 4; i++) begin
        if (portBuf[refP][i] !== 8'h00) bad++;
      end
      checkOutput($sformatf("v%0d pad", v), bad, 0);

      r = 32'hFFFF_FFFF;
      for (int k = 0; k < n; k++) r = refCrcByte(r, portBuf[refP][k]);
      checkOutput($sformatf("v%0d residue", v), rev32(r), 32'hC704_DD7B);

      checkOutput($sformatf("v%0d delCount", v), delSeen[refP], 1);
      checkOutput($sformatf("v%0d delIndex", v), delIdx[refP], vecs[v].expLen - 1);

      bad = 0;
      for (int p = 0; p < 4; p++) begin
        if (vecs[v].mask[p] && p != refP) begin
          for (int k = 0; k < n; k++) begin
            if (portBuf[p][k] !== portBuf[refP][k]) bad++;
          end
        end
      end
      checkOutput($sformatf("v%0d portsEqual", v), bad, 0);
    end
  endtask

  initial begin
    int waitC;
    vecCount    = 0;
    checkCount  = 0;
    miscompares = 0;
    bubblePct   = 0;
    stallLeft   = 0;
    stallAt     = 0;
    stallBits   = '0;
    doneCnt     = 0;
    dropCnt     = 0;
    popCnt      = 0;
    for (int p = 0; p < 4; p++) portCnt[p] = 0;

    //          mask     len   bub stPop stCyc stBits   expLen drop
    vecs[0] = '{4'b0010,   60,  0,   0,    0, 4'b0000,   78, 1'b0};
    vecs[1] = '{4'b0001,   10,  0,   0,    0, 4'b0000,   64, 1'b0};
    vecs[2] = '{4'b1111,   46,  0,  20,   20, 4'b0100,   64, 1'b0};
    vecs[3] = '{4'b0000,  100,  0,   0,    0, 4'b0000,    0, 1'b1};
    vecs[4] = '{4'b1000, 1500, 30,   0,    0, 4'b0000, 1518, 1'b0};
    vecs[5] = '{4'b0101,   45,  0,   0,    0, 4'b0000,   64, 1'b0};
    vecs[6] = '{4'b0100,   47,  0,   0,    0, 4'b0000,   65, 1'b0};
    vecs[7] = '{4'b0001,   60,  0,   0,    0, 4'b0000,   78, 1'b0};
    vecs[8] = '{4'b0011,   60,  0,   0,    0, 4'b0000,   78, 1'b0};

    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetState",
                {o_fifo_din, o_fifo_wren, o_fifo_del, frame_done, frame_drop, h_fifo_rden, b_fifo_rden}, 0);
    #2 arst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      $display("[TB] frame %0d: mask %b, %0d body bytes", v, vecs[v].mask, vecs[v].len);
      applyStimulus(v);
      checkFrame(v);
      vecCount++;
    end

    // Reset in the middle of a payload, then a clean frame afterwards.
    $display("[TB] frame 7: reset mid-payload");
    applyStimulus(7);
    waitC = 0;
    while (popCnt < 20 && waitC < 2000) begin
      @(negedge clk);
      waitC++;
    end
    checkOutput("abortReached", (popCnt >= 20) ? 1 : 0, 1);
    #2 arst_n = 1'b0;
    hq.delete();
    bq.delete();
    stallLeft = 0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midResetOutputs",
                  {o_fifo_din, o_fifo_wren, o_fifo_del, frame_done, frame_drop, h_fifo_rden, b_fifo_rden}, 0);
    end
    #2 arst_n = 1'b1;
    repeat (2) @(negedge clk);
    vecCount++;

    $display("[TB] frame 8: after reset");
    applyStimulus(8);
    checkFrame(8);
    vecCount++;

    $display("[TB] %0d comparisons made", checkCount);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
